decoder_scan_param: RTL and testbench
=====================================

# decoder_scan_param

Parametrised registered N-to-2^N one-hot decoder and the next generation of the lab 3-to-8 decoder. It adds a clocked output stage, enable gating and an autonomous scan mode that walks the one-hot output through every line with a programmable dwell time. It drives multiplexed loads such as digit strobes and row selects.

## Interface

- `N`, default 3: select width. Output width is `M = 2**N`. Legal range 1..6.
- `DWELL`, default 4: number of cycles each line is held in scan mode. Legal range 1..65535.
- `CLK`  in  1: rising-edge clock.
- `RST_N`  in  1: asynchronous, active-low reset.
- `EN`  in  1: decoder enable. 0 forces all outputs low.
- `MODE`  in  1: 0 = direct decode of `I`, 1 = autonomous scan.
- `I`  in  N: select input, used in direct mode only.
- `D`  out  M: registered one-hot output.
- `IDX`  out  N: registered index of the active line.
- `WRAP`  out  1: one-cycle pulse when the scan index wraps from M-1 to 0.

One clock; reset is asynchronous and active-low.

## Operation

- State machine has three states: IDLE, DIRECT and SCAN. All outputs are registered.
- **Reset:** state = IDLE, `D` = 0, `IDX` = 0, `WRAP` = 0, dwell counter = 0.
- **IDLE:**
  - `D` = 0 and `IDX` = 0.
  - `EN`=1 and `MODE`=0 → DIRECT.
  - `EN`=1 and `MODE`=1 → SCAN.
- **DIRECT:**
  - Each edge sets `D` ← 1<<`I` and `IDX` ← `I`.
  - `EN`=0 → IDLE, with `D` = 0 after that edge.
  - `MODE`=1 → SCAN.
- **SCAN entry** (from IDLE or DIRECT): `D` ← 1, `IDX` ← 0, dwell ← 0, `WRAP` ← 0.
- **SCAN running:**
  - Each edge sets dwell ← dwell+1.
  - When dwell = `DWELL`-1: dwell ← 0 and `IDX` ← `IDX`+1 mod M, and `D` follows `IDX`.
- **SCAN wrap:** the step from `IDX` = M-1 to 0 sets `WRAP` = 1 for exactly that one cycle. Scan entry never asserts `WRAP`.
- **`DWELL` = 1:** the index advances on every edge.
- **Leaving SCAN:**
  - `EN`=0 → IDLE.
  - `MODE`=0 → DIRECT, which decodes `I` on that same edge.
  - Dwell and index are discarded, so re-entry always restarts at line 0.
- **Invariant:** `D` is either zero or exactly one-hot. Outside blanking, `D` = 1<<`IDX` whenever `D` ≠ 0.
- **Priority:** `EN` has priority over `MODE`, and `MODE` changes take effect on the next edge.
- **Illegal parameters:** an `N` or `DWELL` outside its legal range causes an elaboration-time error.

## Timing

- Direct-mode latency is 1 cycle: `I` sampled at edge k appears on `D` after edge k.
- Scan period is M×`DWELL` cycles, and `WRAP` pulses once per period.
- `RST_N` asserted at any time, including mid-dwell, clears all outputs immediately without waiting for `CLK`.
- The first edge after `RST_N` deasserts is a normal evaluation edge from IDLE.
- No combinational path exists from any input to any output.

## Configuration

- **`DECODER_SCAN_BLANK_EN` defined:**
  - In SCAN, `D` = 0 during the final cycle of each dwell period (dwell = `DWELL`-1). This gives anti-ghosting between lines.
  - `IDX` and `WRAP` timing are unchanged.
  - `DWELL` must be ≥ 2, otherwise elaboration fails.
  - DIRECT and IDLE behaviour is unaffected.
- **Undefined:** `D` is held for the full dwell period, with no blank cycle.

## Test plan

All scenarios use defaults (`N`=3, `DWELL`=4) unless stated.

1. **Direct sweep:** drive all 16 `{EN,I}` combinations in direct mode. After each edge, `D` = 8'h00 for `EN`=0, otherwise 1<<`I`. Example: `I`=3'b101 gives `D`=8'h20 and `IDX`=5.
2. **Full scan:** set `EN`=1, `MODE`=1 from IDLE.
   - `D` = 8'h01 after edges 1–4, then 8'h02 after edges 5–8, continuing to 8'h80 after edges 29–32.
   - At edge 33, `D` = 8'h01 with `WRAP` = 1 for one cycle only.
3. **Mode switch:** at `IDX`=5 mid-dwell, set `MODE`=0 with `I`=2. The next edge gives `D`=8'h04. Returning to `MODE`=1 restarts at `D`=8'h01 with `WRAP`=0.
4. **Async reset:** assert `RST_N` low between clock edges at `IDX`=6. `D`=0, `IDX`=0 and `WRAP`=0 immediately. After release, scan restarts at line 0.
5. **Enable drop:** at `IDX`=3, set `EN`=0. The next edge gives `D`=0 and `IDX`=0. Setting `EN`=1 restarts at 8'h01.
6. **Blanking:** with `DECODER_SCAN_BLANK_EN` defined, `D` runs 01,01,01,00, then 02,02,02,00, and so on. `IDX` and `WRAP` match scenario 2 exactly.

Source files
------------

// File: rtl/decoder_scan_param.sv
// decoder_scan_param: registered N-to-2^N one-hot decoder with enable gating
// and an autonomous scan mode that walks the active line with a programmable
// dwell time. All outputs are registered; reset is asynchronous, active-low.
// Optional build macro: DECODER_SCAN_BLANK_EN blanks D during the last cycle
// of every scan dwell period (anti-ghosting between lines); requires DWELL>=2.
module decoder_scan_param #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              MODE,
  input  logic [N-1:0]      I,
  output logic [(2**N)-1:0] D,
  output logic [N-1:0]      IDX,
  output logic              WRAP
);

  localparam int          M          = 2 ** N;
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [N-1:0] IDX_LAST  = {N{1'b1}};

  if (N < 1 || N > 6) begin : g_bad_n
    $error("decoder_scan_param: N=%0d outside legal range 1..6", N);
  end
  if (DWELL < 1 || DWELL > 65535) begin : g_bad_dwell
    $error("decoder_scan_param: DWELL=%0d outside legal range 1..65535", DWELL);
  end
`ifdef DECODER_SCAN_BLANK_EN
  if (DWELL < 2) begin : g_bad_blank
    $error("decoder_scan_param: blanking needs DWELL>=2, got %0d", DWELL);
  end
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] dwell;
  logic [15:0] dwell_nxt;
  logic [M-1:0] d_nxt;
  logic [N-1:0] idx_nxt;
  logic         wrap_nxt;

  function automatic logic [M-1:0] onehot(input logic [N-1:0] sel);
    logic [M-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: EN dominates, then MODE selects direct or scan
  always_comb begin
    state_nxt = S_IDLE;
    if (EN) state_nxt = MODE ? S_SCAN : S_DIRECT;
  end

  // Next values of the registered outputs and the dwell counter
  always_comb begin
    d_nxt     = '0;
    idx_nxt   = '0;
    wrap_nxt  = 1'b0;
    dwell_nxt = '0;
    case (state_nxt)
      S_DIRECT: begin
        d_nxt   = onehot(I);
        idx_nxt = I;
      end
      S_SCAN: begin
        if (state == S_SCAN) begin
          if (dwell == DWELL_LAST) begin
            idx_nxt  = IDX + 1'b1;
            wrap_nxt = (IDX == IDX_LAST);
          end else begin
            idx_nxt   = IDX;
            dwell_nxt = dwell + 16'd1;
          end
        end
        // Entering scan leaves idx/dwell at zero so the walk starts at line 0
        d_nxt = onehot(idx_nxt);
`ifdef DECODER_SCAN_BLANK_EN
        if (dwell_nxt == DWELL_LAST) d_nxt = '0;
`endif
      end
      default: begin
        d_nxt = '0;
      end
    endcase
  end

  // Output and dwell registers, cleared asynchronously by reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      D     <= '0;
      IDX   <= '0;
      WRAP  <= 1'b0;
      dwell <= '0;
    end else begin
      D     <= d_nxt;
      IDX   <= idx_nxt;
      WRAP  <= wrap_nxt;
      dwell <= dwell_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_scan_param.sv
// Bench for decoder_scan_param (N=3, DWELL=4): directed test-plan scenarios
// plus a randomized run, all compared against a behavioural model that
// derives expected outputs from the time spent in scan mode.
module tb_decoder_scan_param;

  localparam int N     = 3;
  localparam int DWELL = 4;
  localparam int M     = 2 ** N;

  logic         CLK;
  logic         RST_N;
  logic         EN;
  logic         MODE;
  logic [N-1:0] I;
  logic [M-1:0] D;
  logic [N-1:0] IDX;
  logic         WRAP;

  int checks = 0;
  int errors = 0;

  // Behavioural model: scan_t counts edges since scan entry (-1 = not scanning)
  int scan_t = -1;
  int m_d    = 0;
  int m_idx  = 0;
  int m_wrap = 0;

  decoder_scan_param #(.N(N), .DWELL(DWELL)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .EN   (EN),
    .MODE (MODE),
    .I    (I),
    .D    (D),
    .IDX  (IDX),
    .WRAP (WRAP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    scan_t = -1;
    m_d    = 0;
    m_idx  = 0;
    m_wrap = 0;
  endtask

  task automatic model_edge();
    if (!EN) begin
      model_clear();
    end else if (!MODE) begin
      scan_t = -1;
      m_idx  = int'(I);
      m_d    = 1 << m_idx;
      m_wrap = 0;
    end else begin
      scan_t = scan_t + 1;
      m_idx  = (scan_t / DWELL) % M;
      m_wrap = (scan_t > 0 && (scan_t % (M * DWELL)) == 0) ? 1 : 0;
      m_d    = 1 << m_idx;
`ifdef DECODER_SCAN_BLANK_EN
      if ((scan_t % DWELL) == DWELL - 1) m_d = 0;
`endif
    end
  endtask

  task automatic step(input logic e, input logic md, input logic [N-1:0] sel);
    EN   = e;
    MODE = md;
    I    = sel;
    @(posedge CLK);
    model_edge();
    #1;
    check("D", 64'(D), 64'(m_d));
    check("IDX", 64'(IDX), 64'(m_idx));
    check("WRAP", 64'(WRAP), 64'(m_wrap));
    check("ONEHOT0", 64'($onehot0(D)), 64'd1);
  endtask

  initial begin
    logic rnd_mode;
    RST_N = 1'b0;
    EN    = 1'b0;
    MODE  = 1'b0;
    I     = '0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    check("RST_D", 64'(D), 64'd0);
    check("RST_IDX", 64'(IDX), 64'd0);
    check("RST_WRAP", 64'(WRAP), 64'd0);
    RST_N = 1'b1;

    // Direct sweep over all {EN,I}
    for (int e = 0; e < 2; e++)
      for (int s = 0; s < M; s++)
        step(e[0], 1'b0, s[N-1:0]);
    step(1'b1, 1'b0, 3'b101);
    check("DIR_D_101", 64'(D), 64'h20);
    check("DIR_IDX_101", 64'(IDX), 64'd5);

    // Full scan from IDLE
    step(1'b0, 1'b0, '0);
    for (int k = 1; k <= 33; k++) begin
      step(1'b1, 1'b1, 3'($urandom_range(0, M - 1)));
      if (k == 5) check("SCAN_E5_D", 64'(D), 64'h02);
      if (k == 32) check("SCAN_E32_IDX", 64'(IDX), 64'd7);
      if (k == 32) check("SCAN_E32_WRAP", 64'(WRAP), 64'd0);
    end
    check("SCAN_E33_D", 64'(D), 64'h01);
    check("SCAN_E33_WRAP", 64'(WRAP), 64'd1);
    step(1'b1, 1'b1, '0);
    check("SCAN_E34_WRAP", 64'(WRAP), 64'd0);

    // Mode switch mid-dwell at IDX=5
    step(1'b0, 1'b0, '0);
    for (int k = 0; k < 22; k++) step(1'b1, 1'b1, '0);
    check("MSW_IDX5", 64'(IDX), 64'd5);
    step(1'b1, 1'b0, 3'd2);
    check("MSW_D04", 64'(D), 64'h04);
    step(1'b1, 1'b1, '0);
    check("MSW_RESTART_D", 64'(D), 64'h01);
    check("MSW_RESTART_WRAP", 64'(WRAP), 64'd0);

    // Asynchronous reset between edges at IDX=6
    step(1'b0, 1'b0, '0);
    for (int k = 0; k < 26; k++) step(1'b1, 1'b1, '0);
    check("ARST_PRE_IDX6", 64'(IDX), 64'd6);
    #3;
    RST_N = 1'b0;
    #1;
    model_clear();
    check("ARST_D", 64'(D), 64'd0);
    check("ARST_IDX", 64'(IDX), 64'd0);
    check("ARST_WRAP", 64'(WRAP), 64'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    step(1'b1, 1'b1, '0);
    check("ARST_RESTART_D", 64'(D), 64'h01);

    // Enable drop at IDX=3
    for (int k = 0; k < 12; k++) step(1'b1, 1'b1, '0);
    check("END_PRE_IDX3", 64'(IDX), 64'd3);
    step(1'b0, 1'b1, '0);
    check("END_D", 64'(D), 64'd0);
    check("END_IDX", 64'(IDX), 64'd0);
    step(1'b1, 1'b1, '0);
    check("END_RESTART_D", 64'(D), 64'h01);

    // Randomized run with sticky mode and occasional enable drops
    rnd_mode = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 29) == 0) rnd_mode = ~rnd_mode;
      step(($urandom_range(0, 24) != 0), rnd_mode, 3'($urandom_range(0, M - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
